ddr2_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single byte-wide ram_interface_wrapper port among NUM_REQ clients.

---
 rtl/ddr2_port_arbiter_pkg.sv | 17 +
 rtl/ddr2_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/ddr2_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ddr2_port_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_port_arbiter_pkg.sv
// Shared types and defaults for the DDR2 port arbiter.
package ddr2_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF  = 26;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned NUM_REQ_DEF = 2;
  localparam int unsigned STATE_W     = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_ACK  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/ddr2_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_mask searching from ptr+1.
module ddr2_port_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   index,
  output logic               any
);

  // Walk the clients in rotating order; the nearest one after ptr wins.
  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] cand;
    winner = '0;
    index  = '0;
    any    = 1'b0;
    j      = 0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j    = (32'(ptr) + k) % NUM_REQ;
      cand = IDX_W'(j);
      if (!any && req_mask[cand]) begin
        any          = 1'b1;
        winner[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/ddr2_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide ram_interface_wrapper port among
// NUM_REQ clients. Optional read watchdog: define DDR2_ARB_TIMEOUT_EN.
module ddr2_port_arbiter
  import ddr2_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
`ifdef DDR2_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_gnt,
  output logic [NUM_REQ-1:0]          req_done,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_in,
  output logic                        mem_write_enable,
  output logic                        mem_read_request,
  output logic                        mem_read_ack,
  input  logic [DATA_W-1:0]           mem_data_out,
  input  logic                        mem_rdy,
  input  logic                        mem_rd_data_pres,
  input  logic [ADDR_W-1:0]           max_ram_address
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e state_q, state_nxt;
  logic [IDX_W-1:0]   ptr_q, ptr_nxt;
  logic [NUM_REQ-1:0] owner_q, owner_nxt;

  logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
  logic               err_nxt, we_nxt, rreq_nxt, ack_nxt;
  logic [DATA_W-1:0]  data_nxt, wdata_nxt;
  logic [ADDR_W-1:0]  addr_nxt;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

`ifdef DDR2_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_cnt_q, wd_cnt_nxt;
`endif

  // Unflatten client address/data buses.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  ddr2_port_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_mask (req_valid),
    .ptr      (ptr_q),
    .winner   (win_oh),
    .index    (win_idx),
    .any      (win_any)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    owner_nxt = owner_q;
    gnt_nxt   = '0;
    done_nxt  = '0;
    we_nxt    = 1'b0;
    rreq_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = rsp_err;
    data_nxt  = rsp_data;
    addr_nxt  = mem_address;
    wdata_nxt = mem_data_in;
`ifdef DDR2_ARB_TIMEOUT_EN
    wd_cnt_nxt = '0;
`endif
    case (state_q)
      IDLE: begin
        // Skip the cycle a grant is visible so a client dropping valid is not re-granted.
        if (mem_rdy && win_any && (req_gnt == '0)) begin
          ptr_nxt   = win_idx;
          owner_nxt = win_oh;
          gnt_nxt   = win_oh;
          if (addr_a[win_idx] > max_ram_address) begin
            done_nxt = win_oh;
            err_nxt  = 1'b1;
            data_nxt = '0;
          end else begin
            addr_nxt  = addr_a[win_idx];
            wdata_nxt = wdata_a[win_idx];
            if (req_we[win_idx]) begin
              we_nxt    = 1'b1;
              state_nxt = WR;
            end else begin
              rreq_nxt  = 1'b1;
              state_nxt = RD_REQ;
            end
          end
        end
      end
      WR: begin
        done_nxt  = owner_q;
        err_nxt   = 1'b0;
        data_nxt  = '0;
        state_nxt = IDLE;
      end
      RD_REQ: begin
        state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rd_data_pres) begin
          data_nxt  = mem_data_out;
          err_nxt   = 1'b0;
          ack_nxt   = 1'b1;
          done_nxt  = owner_q;
          state_nxt = RD_ACK;
        end
`ifdef DDR2_ARB_TIMEOUT_EN
        else if (wd_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          ack_nxt   = 1'b1;
          done_nxt  = owner_q;
          state_nxt = IDLE;
        end else begin
          wd_cnt_nxt = wd_cnt_q + TO_W'(1);
        end
`endif
      end
      RD_ACK: begin
        // Hold off until the wrapper drops data-present to avoid a second capture.
        if (!mem_rd_data_pres) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      ptr_q            <= IDX_W'(NUM_REQ - 1);
      owner_q          <= '0;
      req_gnt          <= '0;
      req_done         <= '0;
      rsp_err          <= 1'b0;
      rsp_data         <= '0;
      busy             <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
      mem_read_request <= 1'b0;
      mem_read_ack     <= 1'b0;
`ifdef DDR2_ARB_TIMEOUT_EN
      wd_cnt_q         <= '0;
`endif
    end else begin
      state_q          <= state_nxt;
      ptr_q            <= ptr_nxt;
      owner_q          <= owner_nxt;
      req_gnt          <= gnt_nxt;
      req_done         <= done_nxt;
      rsp_err          <= err_nxt;
      rsp_data         <= data_nxt;
      busy             <= (state_nxt != IDLE);
      mem_address      <= addr_nxt;
      mem_data_in      <= wdata_nxt;
      mem_write_enable <= we_nxt;
      mem_read_request <= rreq_nxt;
      mem_read_ack     <= ack_nxt;
`ifdef DDR2_ARB_TIMEOUT_EN
      wd_cnt_q         <= wd_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Self-checking bench for ddr2_port_arbiter with a wrapper model and a
// request-level reference model. Timeout scenario under DDR2_ARB_TIMEOUT_EN.
module tb_ddr2_port_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] MAX_ADDR = 26'h3F;
`ifdef DDR2_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 1023;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_gnt, req_done;
  logic            rsp_err, busy;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_data_in;
  logic            mem_write_enable, mem_read_request, mem_read_ack;
  logic [DW-1:0]   mem_data_out;
  logic            mem_rdy, mem_rd_data_pres;
  logic [AW-1:0]   max_ram_address;

  int n_cmp = 0;
  int n_err = 0;

  // wrapper model state
  logic [DW-1:0] wmem [256];
  logic          rd_busy;
  int            rd_cnt;
  logic [7:0]    rd_a;
  int            rd_lat;
  logic          no_resp;

  // reference model state
  logic [DW-1:0] ref_mem [256];
  int            mptr;

  // strobe monitors
  int   we_cnt = 0, rr_cnt = 0, ack_cnt = 0, dbl_cnt = 0;
  logic we_prev, rr_prev, ack_prev;

  always #5 clk = ~clk;

  ddr2_port_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_gnt          (req_gnt),
    .req_done         (req_done),
    .rsp_err          (rsp_err),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_write_enable),
    .mem_read_request (mem_read_request),
    .mem_read_ack     (mem_read_ack),
    .mem_data_out     (mem_data_out),
    .mem_rdy          (mem_rdy),
    .mem_rd_data_pres (mem_rd_data_pres),
    .max_ram_address  (max_ram_address)
  );

  function automatic logic [7:0] pat(int i);
    return 8'(i * 37 + 5);
  endfunction

  // Wrapper model: write on strobe, read data after rd_lat cycles, hold until ack.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) wmem[i] <= pat(i);
      rd_busy          <= 1'b0;
      rd_cnt           <= 0;
      rd_a             <= '0;
      mem_rd_data_pres <= 1'b0;
      mem_data_out     <= '0;
    end else begin
      if (mem_write_enable) wmem[mem_address[7:0]] <= mem_data_in;
      if (mem_read_request) begin
        rd_busy <= 1'b1;
        rd_cnt  <= rd_lat;
        rd_a    <= mem_address[7:0];
      end else if (rd_busy && !no_resp) begin
        if (rd_cnt <= 1) begin
          rd_busy          <= 1'b0;
          mem_rd_data_pres <= 1'b1;
          mem_data_out     <= wmem[rd_a];
        end else begin
          rd_cnt <= rd_cnt - 1;
        end
      end
      if (mem_rd_data_pres && mem_read_ack) mem_rd_data_pres <= 1'b0;
    end
  end

  // Strobe counters and back-to-back strobe detection.
  always @(posedge clk) begin
    if (reset) begin
      we_prev  <= 1'b0;
      rr_prev  <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      if (mem_write_enable) we_cnt <= we_cnt + 1;
      if (mem_read_request) rr_cnt <= rr_cnt + 1;
      if (mem_read_ack)     ack_cnt <= ack_cnt + 1;
      if ((mem_write_enable && we_prev) || (mem_read_request && rr_prev) ||
          (mem_read_ack && ack_prev)) dbl_cnt <= dbl_cnt + 1;
      we_prev  <= mem_write_enable;
      rr_prev  <= mem_read_request;
      ack_prev <= mem_read_ack;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_init();
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    mptr = N - 1;
  endtask

  task automatic set_req(int c, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_we[c]              = we;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = d;
    req_valid[c]           = 1'b1;
  endtask

  // Reference round-robin choice: nearest valid client after the last winner.
  function automatic int rr_pick(logic [N-1:0] m, int p);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (p + k) % N;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic wait_idle(string tag);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 2000) begin tick(); c++; end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle wait: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    logic [50:0] all_out;
    reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_rdy = 1'b1; no_resp = 1'b0; rd_lat = 3; max_ram_address = MAX_ADDR;
    ref_init();
    tick(); tick();
    all_out = {req_gnt, req_done, rsp_err, rsp_data, busy, mem_address, mem_data_in,
               mem_write_enable, mem_read_request, mem_read_ack};
    n_cmp++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset outputs: got %h required 0", all_out); end
    reset = 1'b0;
    tick(); tick();
    all_out = {req_gnt, req_done, rsp_err, rsp_data, busy, mem_address, mem_data_in,
               mem_write_enable, mem_read_request, mem_read_ack};
    n_cmp++;
    if (all_out !== '0) begin n_err++; $display("FAIL idle after reset: got %h required 0", all_out); end
  endtask

  task automatic test_write();
    set_req(0, 1'b1, 26'h10, 8'h5A);
    tick();
    n_cmp++;
    if (req_gnt !== 2'b01 || mem_write_enable !== 1'b1 || mem_address !== 26'h10 ||
        mem_data_in !== 8'h5A || busy !== 1'b1) begin
      n_err++;
      $display("FAIL write cycle1: gnt=%b we=%b addr=%h din=%h busy=%b required 01 1 10 5a 1",
               req_gnt, mem_write_enable, mem_address, mem_data_in, busy);
    end
    mptr = 0; ref_mem[8'h10] = 8'h5A;
    req_valid = '0;
    tick();
    n_cmp++;
    if (req_done !== 2'b01 || rsp_err !== 1'b0 || mem_write_enable !== 1'b0 || req_gnt !== 2'b00) begin
      n_err++;
      $display("FAIL write cycle2: done=%b err=%b we=%b gnt=%b required 01 0 0 00",
               req_done, rsp_err, mem_write_enable, req_gnt);
    end
    tick();
    n_cmp++;
    if (req_done !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL write cycle3: done=%b busy=%b required 00 0", req_done, busy);
    end
  endtask

  task automatic test_read();
    int rr0, ack0, c;
    logic ack_at_done;
    rr0 = rr_cnt; ack0 = ack_cnt;
    rd_lat = 7;
    set_req(1, 1'b0, 26'h10, 8'h00);
    tick();
    n_cmp++;
    if (req_gnt !== 2'b10 || mem_read_request !== 1'b1 || mem_address !== 26'h10) begin
      n_err++;
      $display("FAIL read grant: gnt=%b rreq=%b addr=%h required 10 1 10",
               req_gnt, mem_read_request, mem_address);
    end
    mptr = 1;
    req_valid = '0;
    c = 0;
    while (req_done === 2'b00 && c < 60) begin tick(); c++; end
    ack_at_done = mem_read_ack;
    n_cmp++;
    if (req_done !== 2'b10 || rsp_data !== ref_mem[8'h10] || rsp_err !== 1'b0 || ack_at_done !== 1'b1) begin
      n_err++;
      $display("FAIL read done: done=%b data=%h err=%b ack=%b required 10 %h 0 1",
               req_done, rsp_data, rsp_err, ack_at_done, ref_mem[8'h10]);
    end
    wait_idle("read");
    n_cmp++;
    if (rr_cnt - rr0 != 1 || ack_cnt - ack0 != 1) begin
      n_err++;
      $display("FAIL read strobes: read_request=%0d read_ack=%0d required 1 1", rr_cnt - rr0, ack_cnt - ack0);
    end
  endtask

  task automatic test_alternate();
    int seq [4];
    int ng, c, w, we0;
    logic [N-1:0] exp_oh;
    we0 = we_cnt;
    set_req(0, 1'b1, 26'h01, 8'($urandom));
    set_req(1, 1'b1, 26'h02, 8'($urandom));
    ng = 0; c = 0;
    while (ng < 4 && c < 60) begin
      tick(); c++;
      if (req_gnt !== 2'b00) begin
        w = rr_pick(req_valid, mptr);
        exp_oh = '0; exp_oh[w] = 1'b1;
        n_cmp++;
        if (req_gnt !== exp_oh) begin
          n_err++;
          $display("FAIL alternate grant %0d: got %b required %b", ng, req_gnt, exp_oh);
        end
        mptr = w;
        seq[ng] = w;
        ref_mem[8'(w + 1)] = req_wdata[w*DW +: DW];
        req_wdata[w*DW +: DW] = 8'($urandom);
        ng++;
      end
    end
    req_valid = '0;
    n_cmp++;
    if (ng != 4 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
      n_err++;
      $display("FAIL alternate order: got %0d grants %0d%0d%0d%0d required 4 grants 0101",
               ng, seq[0], seq[1], seq[2], seq[3]);
    end
    wait_idle("alternate");
    n_cmp++;
    if (we_cnt - we0 != 4 || dbl_cnt != 0) begin
      n_err++;
      $display("FAIL alternate strobes: writes=%0d doubles=%0d required 4 0", we_cnt - we0, dbl_cnt);
    end
  endtask

  task automatic test_rdy_low();
    int bad;
    mem_rdy = 1'b0;
    set_req(0, 1'b1, 26'h05, 8'h33);
    bad = 0;
    repeat (20) begin
      tick();
      if (req_gnt !== 2'b00 || mem_write_enable || mem_read_request) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL rdy low: grant/strobe cycles=%0d required 0", bad); end
    mem_rdy = 1'b1;
    tick();
    n_cmp++;
    if (req_gnt !== 2'b01 || mem_write_enable !== 1'b1) begin
      n_err++;
      $display("FAIL rdy rise grant: gnt=%b we=%b required 01 1", req_gnt, mem_write_enable);
    end
    mptr = 0; ref_mem[8'h05] = 8'h33;
    req_valid = '0;
    wait_idle("rdy");
  endtask

  task automatic test_oob();
    int we0, rr0;
    we0 = we_cnt; rr0 = rr_cnt;
    set_req(0, 1'b0, MAX_ADDR + 26'd1, 8'h00);
    tick();
    n_cmp++;
    if (req_gnt !== 2'b01 || req_done !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 8'h00 ||
        mem_write_enable || mem_read_request) begin
      n_err++;
      $display("FAIL out of range: gnt=%b done=%b err=%b data=%h we=%b rreq=%b required 01 01 1 00 0 0",
               req_gnt, req_done, rsp_err, rsp_data, mem_write_enable, mem_read_request);
    end
    mptr = 0;
    req_valid = '0;
    tick(); tick();
    n_cmp++;
    if (we_cnt != we0 || rr_cnt != rr0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL out of range strobes: writes=%0d reads=%0d busy=%b required 0 0 0",
               we_cnt - we0, rr_cnt - rr0, busy);
    end
  endtask

  task automatic test_random(int rounds);
    for (int r = 0; r < rounds; r++) begin
      logic [N-1:0]  mask, pend, outst, exp_oh;
      logic          c_we [N];
      logic [AW-1:0] c_addr [N];
      logic [DW-1:0] c_data [N];
      logic          e_err [N];
      logic [DW-1:0] e_data [N];
      int cyc, w, d;
      wait_idle("random");
      mask = N'($urandom_range(1, 3));
      rd_lat = $urandom_range(1, 6);
      for (int c = 0; c < N; c++) begin
        c_we[c] = 1'($urandom);
        c_addr[c] = ($urandom_range(0, 4) == 0) ? MAX_ADDR + AW'($urandom_range(1, 4))
                                                 : AW'($urandom_range(0, 63));
        c_data[c] = 8'($urandom);
        e_err[c] = 1'b0; e_data[c] = '0;
        if (mask[c]) set_req(c, c_we[c], c_addr[c], c_data[c]);
      end
      pend = mask; outst = mask; cyc = 0;
      while (outst != '0 && cyc < 300) begin
        tick(); cyc++;
        mem_rdy = ($urandom_range(0, 3) != 0);
        if (req_gnt !== '0) begin
          w = rr_pick(pend, mptr);
          exp_oh = '0;
          if (w >= 0) exp_oh[w] = 1'b1;
          n_cmp++;
          if (req_gnt !== exp_oh) begin
            n_err++;
            $display("FAIL random grant r%0d: got %b required %b", r, req_gnt, exp_oh);
          end
          if (w >= 0) begin
            mptr = w; pend[w] = 1'b0; req_valid[w] = 1'b0;
            if (c_addr[w] > MAX_ADDR) begin
              e_err[w] = 1'b1; e_data[w] = '0;
            end else begin
              if (c_we[w]) ref_mem[c_addr[w][7:0]] = c_data[w];
              else e_data[w] = ref_mem[c_addr[w][7:0]];
              n_cmp++;
              if (mem_write_enable !== c_we[w] || mem_read_request !== !c_we[w] ||
                  mem_address !== c_addr[w] || (c_we[w] && mem_data_in !== c_data[w])) begin
                n_err++;
                $display("FAIL random strobe r%0d: we=%b rreq=%b addr=%h din=%h required %b %b %h %h",
                         r, mem_write_enable, mem_read_request, mem_address, mem_data_in,
                         c_we[w], !c_we[w], c_addr[w], c_data[w]);
              end
            end
          end
        end
        if (req_done !== '0) begin
          d = -1;
          for (int c = 0; c < N; c++) if (req_done == N'(1 << c)) d = c;
          n_cmp++;
          if (d < 0 || !outst[d] || pend[d]) begin
            n_err++;
            $display("FAIL random done r%0d: got %b outstanding %b", r, req_done, outst & ~pend);
          end else begin
            outst[d] = 1'b0;
            if (rsp_err !== e_err[d] || ((!c_we[d] || e_err[d]) && rsp_data !== e_data[d])) begin
              n_err++;
              $display("FAIL random rsp r%0d c%0d: err=%b data=%h required %b %h",
                       r, d, rsp_err, rsp_data, e_err[d], e_data[d]);
            end
          end
        end
      end
      mem_rdy = 1'b1;
      n_cmp++;
      if (outst != '0) begin
        n_err++;
        $display("FAIL random round %0d timeout: outstanding %b required 00", r, outst);
        req_valid = '0;
      end
    end
  endtask

  task automatic test_reset_rd_wait();
    logic [50:0] all_out;
    int c, seen;
    no_resp = 1'b1;
    set_req(0, 1'b0, 26'h20, 8'h00);
    tick();
    req_valid = '0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    all_out = {req_gnt, req_done, rsp_err, rsp_data, busy, mem_address, mem_data_in,
               mem_write_enable, mem_read_request, mem_read_ack};
    n_cmp++;
    if (all_out !== '0) begin n_err++; $display("FAIL reset in rd_wait: got %h required 0", all_out); end
    reset = 1'b0;
    no_resp = 1'b0;
    ref_init();
    seen = 0;
    for (c = 0; c < 12; c++) begin
      tick();
      if (req_done !== '0 || busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_err++; $display("FAIL after abort: done/busy cycles=%0d required 0", seen); end
  endtask

`ifdef DDR2_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    logic ack_at_done;
    no_resp = 1'b1;
    set_req(0, 1'b0, 26'h21, 8'h00);
    tick();
    mptr = 0;
    req_valid = '0;
    c = 0;
    while (req_done === 2'b00 && c < TB_TIMEOUT + 50) begin tick(); c++; end
    ack_at_done = mem_read_ack;
    n_cmp++;
    if (req_done !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 8'h00 || ack_at_done !== 1'b1 ||
        c < TB_TIMEOUT || c > TB_TIMEOUT + 2) begin
      n_err++;
      $display("FAIL timeout: done=%b err=%b data=%h ack=%b after %0d cycles required 01 1 00 1 after ~%0d",
               req_done, rsp_err, rsp_data, ack_at_done, c, TB_TIMEOUT);
    end
    reset = 1'b1; tick(); tick(); reset = 1'b0; no_resp = 1'b0; ref_init();
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_rdy_low();
    test_oob();
    test_random(40);
    test_reset_rd_wait();
`ifdef DDR2_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
